// File: rtl/mem_arbiter_pkg.sv
// Shared CPU package: arbiter state encoding, port index constants and
// the round-robin grant helper used by the memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arbState_t;

    // Port indices: instruction fetch and data access.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Round-robin pick: a lone request always wins; on a tie the port that
    // was not granted last time wins.
    function automatic logic pickPort(input logic r0, input logic r1, input logic lastGrant);
        logic winner;
        if (r0 && r1) begin
            winner = ~lastGrant;
        end else if (r1) begin
            winner = PORT_D;
        end else begin
            winner = PORT_I;
        end
        return winner;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: grants the instruction-fetch or data port
// round-robin, drives the memory bus for WAIT_CYCLES cycles, then returns
// read data and a one-cycle ack to the granted port. All outputs registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req0,
    input  logic        rw0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic [31:0] rdata0,
    output logic        ack0,

    input  logic        req1,
    input  logic        rw1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic [31:0] rdata1,
    output logic        ack1,

    output logic        m_en,
    output logic        m_rw,
    output logic [31:0] m_abus,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    // Counter value seen on the final ACCESS edge.
    localparam logic [3:0] LAST_COUNT = 4'(WAIT_CYCLES - 1);

    arbState_t   state_q,     state_d;
    logic [3:0]  cnt_q,       cnt_d;
    logic        lastGrant_q, lastGrant_d;
    logic        grant_q,     grant_d;
    logic        mEn_q,       mEn_d;
    logic        mRw_q,       mRw_d;
    logic [31:0] mAbus_q,     mAbus_d;
    logic [31:0] mWdata_q,    mWdata_d;
    logic [31:0] rdata0_q,    rdata0_d;
    logic [31:0] rdata1_q,    rdata1_d;
    logic        ack0_q,      ack0_d;
    logic        ack1_q,      ack1_d;

    logic        winner;

    assign winner = pickPort(req0, req1, lastGrant_q);

    // Next-state and next-output logic; every register holds unless a state says otherwise.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lastGrant_d = lastGrant_q;
        grant_d     = grant_q;
        mEn_d       = mEn_q;
        mRw_d       = mRw_q;
        mAbus_d     = mAbus_q;
        mWdata_d    = mWdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = ACCESS;
                    grant_d = winner;
                    cnt_d   = 4'd0;
                    mEn_d   = 1'b1;
                    if (winner == PORT_D) begin
                        mRw_d    = rw1;
                        mAbus_d  = addr1;
                        mWdata_d = wdata1;
                    end else begin
                        mRw_d    = rw0;
                        mAbus_d  = addr0;
                        mWdata_d = wdata0;
                    end
                end
            end

            ACCESS: begin
                if (cnt_q == LAST_COUNT) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                    mEn_d   = 1'b0;
                    if (grant_q == PORT_D) begin
                        ack1_d = 1'b1;
                        if (mRw_q) begin
                            rdata1_d = m_rdata;
                        end
                    end else begin
                        ack0_d = 1'b1;
                        if (mRw_q) begin
                            rdata0_d = m_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            DONE: begin
                state_d     = IDLE;
                lastGrant_d = grant_q;
            end

            default: begin
                state_d = IDLE;
                mEn_d   = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            lastGrant_q <= PORT_D;
            grant_q     <= PORT_I;
            mEn_q       <= 1'b0;
            mRw_q       <= 1'b1;
            mAbus_q     <= 32'd0;
            mWdata_q    <= 32'd0;
            rdata0_q    <= 32'd0;
            rdata1_q    <= 32'd0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lastGrant_q <= lastGrant_d;
            grant_q     <= grant_d;
            mEn_q       <= mEn_d;
            mRw_q       <= mRw_d;
            mAbus_q     <= mAbus_d;
            mWdata_q    <= mWdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
        end
    end

    assign m_en    = mEn_q;
    assign m_rw    = mRw_q;
    assign m_abus  = mAbus_q;
    assign m_wdata = mWdata_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign ack0    = ack0_q;
    assign ack1    = ack1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with WAIT_CYCLES=1 and one
// with WAIT_CYCLES=3, each attached to a small word-addressed memory model.
module tb_mem_arbiter;

    logic clock;

    // Instance A (WAIT_CYCLES = 1)
    logic        reset;
    logic        req0, rw0, req1, rw1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [31:0] rdata0, rdata1;
    logic        ack0, ack1;
    logic        mEn, mRw;
    logic [31:0] mAbus, mWdata, mRdata;

    // Instance B (WAIT_CYCLES = 3)
    logic        bReset;
    logic        bReq0, bRw0, bReq1, bRw1;
    logic [31:0] bAddr0, bWdata0, bAddr1, bWdata1;
    logic [31:0] bRdata0, bRdata1;
    logic        bAck0, bAck1;
    logic        bMEn, bMRw;
    logic [31:0] bMAbus, bMWdata, bMRdata;

    logic [31:0] memA [0:63];
    logic [31:0] memB [0:63];
    logic        hitA, hitB;

    int compareCount;
    int failCount;

    mem_arbiter #(.WAIT_CYCLES(1)) u_dutA (
        .clock(clock), .reset(reset),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ack0(ack0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ack1(ack1),
        .m_en(mEn), .m_rw(mRw), .m_abus(mAbus), .m_wdata(mWdata), .m_rdata(mRdata)
    );

    mem_arbiter #(.WAIT_CYCLES(3)) u_dutB (
        .clock(clock), .reset(bReset),
        .req0(bReq0), .rw0(bRw0), .addr0(bAddr0), .wdata0(bWdata0), .rdata0(bRdata0), .ack0(bAck0),
        .req1(bReq1), .rw1(bRw1), .addr1(bAddr1), .wdata1(bWdata1), .rdata1(bRdata1), .ack1(bAck1),
        .m_en(bMEn), .m_rw(bMRw), .m_abus(bMAbus), .m_wdata(bMWdata), .m_rdata(bMRdata)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Memory models: combinational read, write on any enabled write cycle.
    assign hitA   = (mAbus[31:8] == 24'd0) && (mAbus[1:0] == 2'd0);
    assign hitB   = (bMAbus[31:8] == 24'd0) && (bMAbus[1:0] == 2'd0);
    assign mRdata  = hitA ? memA[mAbus[7:2]]  : 32'hDEAD_BEEF;
    assign bMRdata = hitB ? memB[bMAbus[7:2]] : 32'hDEAD_BEEF;

    always @(posedge clock) begin
        if (mEn && !mRw && hitA) memA[mAbus[7:2]] <= mWdata;
        if (bMEn && !bMRw && hitB) memB[bMAbus[7:2]] <= bMWdata;
    end

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        compareCount = 0;
        failCount    = 0;
        clock  = 1'b0;
        reset  = 1'b1;  bReset = 1'b1;
        req0 = 0; rw0 = 1; addr0 = 0; wdata0 = 0;
        req1 = 0; rw1 = 1; addr1 = 0; wdata1 = 0;
        bReq0 = 0; bRw0 = 1; bAddr0 = 0; bWdata0 = 0;
        bReq1 = 0; bRw1 = 1; bAddr1 = 0; bWdata1 = 0;
        for (int i = 0; i < 64; i++) begin
            memA[i] = 32'd0;
            memB[i] = 32'd0;
        end
        memA[0] = 32'h001F_0018;  memA[1] = 32'h002F_0010;
        memB[0] = 32'h001F_0018;  memB[1] = 32'h002F_0010;

        applyStimulus(2);
        reset = 1'b0;  bReset = 1'b0;

        // Reset values
        checkOutput("rst_m_en",    mEn,    32'd0);
        checkOutput("rst_m_rw",    mRw,    32'd1);
        checkOutput("rst_m_abus",  mAbus,  32'd0);
        checkOutput("rst_m_wdata", mWdata, 32'd0);
        checkOutput("rst_ack0",    ack0,   32'd0);
        checkOutput("rst_ack1",    ack1,   32'd0);
        checkOutput("rst_rdata0",  rdata0, 32'd0);
        checkOutput("rst_rdata1",  rdata1, 32'd0);

        // Port 0 read of 0x0, one wait cycle
        req0 = 1; rw0 = 1; addr0 = 32'h0;
        applyStimulus(1);
        checkOutput("r0_access_en",   mEn,   32'd1);
        checkOutput("r0_access_rw",   mRw,   32'd1);
        checkOutput("r0_access_ack0", ack0,  32'd0);
        applyStimulus(1);
        checkOutput("r0_ack0",   ack0,   32'd1);
        checkOutput("r0_ack1",   ack1,   32'd0);
        checkOutput("r0_en_off", mEn,    32'd0);
        checkOutput("r0_rdata0", rdata0, 32'h001F_0018);
        req0 = 0;
        applyStimulus(1);
        checkOutput("r0_ack0_pulse", ack0, 32'd0);

        // Port 1 write of 0xA to 0x20
        req1 = 1; rw1 = 0; addr1 = 32'h20; wdata1 = 32'h0000_000A;
        applyStimulus(1);
        checkOutput("w1_en",    mEn,    32'd1);
        checkOutput("w1_rw",    mRw,    32'd0);
        checkOutput("w1_abus",  mAbus,  32'h20);
        checkOutput("w1_wdata", mWdata, 32'h0000_000A);
        applyStimulus(1);
        checkOutput("w1_ack1",   ack1,   32'd1);
        checkOutput("w1_rdata1", rdata1, 32'd0);
        req1 = 0;
        applyStimulus(1);

        // Port 1 read back of 0x20
        req1 = 1; rw1 = 1; addr1 = 32'h20;
        applyStimulus(2);
        checkOutput("r1_ack1",   ack1,   32'd1);
        checkOutput("r1_rdata1", rdata1, 32'h0000_000A);
        checkOutput("r1_rdata0", rdata0, 32'h001F_0018);
        req1 = 0;
        applyStimulus(1);

        // Simultaneous requests after reset: port 0, then port 1, then port 0
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        req0 = 1; rw0 = 1; addr0 = 32'h0;
        req1 = 1; rw1 = 1; addr1 = 32'h20;
        applyStimulus(1);
        checkOutput("tie1_abus", mAbus, 32'h0);
        applyStimulus(1);
        checkOutput("tie1_ack0", ack0, 32'd1);
        checkOutput("tie1_ack1", ack1, 32'd0);
        applyStimulus(1);
        checkOutput("tie1_idle_ack0", ack0, 32'd0);
        applyStimulus(1);
        checkOutput("tie2_abus", mAbus, 32'h20);
        applyStimulus(1);
        checkOutput("tie2_ack1",   ack1,   32'd1);
        checkOutput("tie2_ack0",   ack0,   32'd0);
        checkOutput("tie2_rdata1", rdata1, 32'h0000_000A);
        applyStimulus(2);
        checkOutput("tie3_abus", mAbus, 32'h0);
        req0 = 0; req1 = 0;
        applyStimulus(1);
        checkOutput("tie3_ack0", ack0, 32'd1);
        checkOutput("tie3_ack1", ack1, 32'd0);
        applyStimulus(1);

        // Port 1 drops req and changes addr mid-access
        req1 = 1; rw1 = 1; addr1 = 32'h20;
        applyStimulus(1);
        checkOutput("drop_abus", mAbus, 32'h20);
        req1 = 0; addr1 = 32'h0;
        applyStimulus(1);
        checkOutput("drop_ack1",   ack1,   32'd1);
        checkOutput("drop_rdata1", rdata1, 32'h0000_000A);
        applyStimulus(1);
        checkOutput("drop_ack1_off", ack1, 32'd0);
        applyStimulus(1);
        checkOutput("drop_no_reaccess", mEn,  32'd0);
        checkOutput("drop_no_reack",    ack1, 32'd0);

        // WAIT_CYCLES=3: port 0 read of 0x4
        bReq0 = 1; bRw0 = 1; bAddr0 = 32'h4;
        applyStimulus(1);
        checkOutput("w3_en_c1", bMEn, 32'd1);
        applyStimulus(1);
        checkOutput("w3_en_c2", bMEn, 32'd1);
        applyStimulus(1);
        checkOutput("w3_en_c3",   bMEn,  32'd1);
        checkOutput("w3_ack0_c3", bAck0, 32'd0);
        applyStimulus(1);
        checkOutput("w3_en_done", bMEn,    32'd0);
        checkOutput("w3_ack0",    bAck0,   32'd1);
        checkOutput("w3_rdata0",  bRdata0, 32'h002F_0010);
        bReq0 = 0;
        applyStimulus(1);

        // WAIT_CYCLES=3: reset in second ACCESS cycle of a port 1 write
        bReq1 = 1; bRw1 = 0; bAddr1 = 32'h8; bWdata1 = 32'h0000_0055;
        applyStimulus(2);
        checkOutput("abort_en_c2", bMEn, 32'd1);
        bReset = 1'b1;
        applyStimulus(1);
        bReset = 1'b0; bReq1 = 0;
        checkOutput("abort_en",     bMEn,    32'd0);
        checkOutput("abort_rw",     bMRw,    32'd1);
        checkOutput("abort_abus",   bMAbus,  32'd0);
        checkOutput("abort_wdata",  bMWdata, 32'd0);
        checkOutput("abort_ack1",   bAck1,   32'd0);
        checkOutput("abort_rdata0", bRdata0, 32'd0);
        checkOutput("abort_rdata1", bRdata1, 32'd0);
        applyStimulus(3);
        checkOutput("abort_no_ack1", bAck1, 32'd0);
        checkOutput("abort_idle_en", bMEn,  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
